// File: rtl/mips_regfile_pkg.sv
// Shared constants, mode encodings and sequencer states for the register-file port master.
package mips_regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMP_ADDR,
    ST_DUMP_CAP,
    ST_DUMP_SEND,
    ST_LOAD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/regfile_range_counter.sv
// Register pointer for a transfer range: loads the first index, wraps modulo NUM_REGS,
// and flags when it sits on the latched last index.
module regfile_range_counter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] ptr_inc,
  output logic              is_last
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;

  always_comb begin
    ptr_inc = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    ptr_d   = ptr_q;
    last_d  = last_q;
    if (load) begin
      ptr_d  = first_reg;
      last_d = last_reg;
    end else if (inc) begin
      ptr_d = ptr_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

  assign ptr     = ptr_q;
  assign is_last = (ptr_q == last_q);

endmodule

// File: rtl/mips_regfile_port_master.sv
// Drives register-file read port 1 and the write port to dump a register range onto a
// valid/ready stream, or to preload consecutive registers from one.
module mips_regfile_port_master
  import mips_regfile_pkg::*;
#(
  parameter int NUM_REGS        = mips_regfile_pkg::NUM_REGS,
  parameter int ADDR_W          = mips_regfile_pkg::ADDR_W,
  parameter int DATA_W          = mips_regfile_pkg::DATA_W,
  parameter bit SKIP_ZERO_WRITE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_reg,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              signal_reg_write,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  state_e state_q, state_d;

  logic busy_q, busy_d, done_q, done_d;
  logic out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] read_reg_q, read_reg_d, write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d, out_data_q, out_data_d;

  logic [ADDR_W-1:0] ptr, ptr_inc;
  logic is_last, ptr_load, ptr_step, out_hs, in_hs;

  assign out_hs   = (state_q == ST_DUMP_SEND) && out_ready;
  assign in_hs    = (state_q == ST_LOAD) && in_ready_q && in_valid;
  assign ptr_load = (state_q == ST_IDLE) && start;
  // The pointer stays on last_reg after the final dump word so is_last remains meaningful.
  assign ptr_step = (out_hs && !is_last) || in_hs;

  regfile_range_counter #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_range_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (ptr_load),
    .inc       (ptr_step),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .ptr       (ptr),
    .ptr_inc   (ptr_inc),
    .is_last   (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      read_reg_q   <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      reg_write_q  <= reg_write_d;
      read_reg_q   <= read_reg_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      out_data_q   <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = (mode == MODE_LOAD) ? ST_LOAD : ST_DUMP_ADDR;
      ST_DUMP_ADDR: state_d = ST_DUMP_CAP;
      ST_DUMP_CAP:  state_d = ST_DUMP_SEND;
      ST_DUMP_SEND: if (out_hs) state_d = is_last ? ST_DONE : ST_DUMP_ADDR;
      ST_LOAD:      if (in_hs && is_last) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Status flags follow the next state so every output leaves a flop.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    in_ready_d   = (state_d == ST_LOAD);
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    read_reg_d   = read_reg_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (mode == MODE_DUMP)) read_reg_d = first_reg;
      end
      ST_DUMP_CAP: begin
        out_data_d  = read_data;
        out_valid_d = 1'b1;
      end
      ST_DUMP_SEND: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          if (!is_last) read_reg_d = ptr_inc;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          write_reg_d  = ptr;
          write_data_d = in_data;
          reg_write_d  = !(SKIP_ZERO_WRITE && (ptr == '0));
        end
      end
      default: ;
    endcase
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign read_reg         = read_reg_q;
  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign signal_reg_write = reg_write_q;
  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign in_ready         = in_ready_q;

endmodule
